tpu_mac: RTL and testbench
==========================

Name:
tpu_mac

Overview:
- Single multiply-accumulate processing element for a systolic-array TPU.
- Holds signed A and B operands and forwards them to its neighbours one cycle later: A to the east, B to the south.
- Accumulates A*B into a signed C register; C can instead be loaded directly, for preload or shift-out.
- Tiled in a 2-D grid by the array top level.

Parameters:
- BITS_AB, 8: width of the signed A and B operands.
- BITS_C, 16: width of the signed accumulator C. Must satisfy BITS_C >= BITS_AB.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst_n, input, 1: reset. Asynchronous and active-high: asserted when 1, despite the name.
- en, input, 1: global enable. When 0, all registers hold.
- WrEn, input, 1: C write-enable. When 1 (and en=1), C loads Cin instead of accumulating.
- Ain, input, BITS_AB: signed A operand from the west neighbour.
- Bin, input, BITS_AB: signed B operand from the north neighbour.
- Cin, input, BITS_C: signed value to load into C.
- Aout, output, BITS_AB: registered A, to the east neighbour.
- Bout, output, BITS_AB: registered B, to the south neighbour.
- Cout, output, BITS_C: registered accumulator value.

Behaviour:
- Reset: while rst_n=1, Aout=0, Bout=0, Cout=0, immediately and independent of clk. After deassertion, outputs stay 0 until the first enabled edge.
- All outputs come directly from registers; no combinational path from any input to any output.
- Rising edge, en=0: Aout, Bout and Cout all hold, regardless of WrEn, Ain, Bin, Cin.
- Rising edge, en=1:
  - Aout <= Ain and Bout <= Bin (one-cycle latency).
  - If WrEn=0: Cout <= Cout + Ain*Bin.
  - If WrEn=1: Cout <= Cin. The product is discarded.
- Enable priority: en gates WrEn; WrEn has no effect when en=0.
- The product uses the current-cycle Ain/Bin inputs, not the registered Aout/Bout.
- Arithmetic:
  - Ain*Bin is a full signed (two's-complement) product of 2*BITS_AB bits.
  - The product is sign-extended or truncated to BITS_C, then added to Cout.
  - The sum wraps modulo 2^BITS_C. No saturation and no overflow flag.
- Reset asserted mid-operation clears all three registers at once; any in-flight accumulation is lost.

Decomposition:
- Shared package tpu_pkg holds the default BITS_AB and BITS_C constants and the typedefs for the A/B and C signed vectors.
- One natural sub-module, tpu_mac_mult: a parameterised signed multiplier with a BITS_C-wide result, so it can later be swapped for a pipelined or DSP version.
- The operand and accumulator registers stay in tpu_mac.

Test Plan:
- Reset: assert rst_n=1 mid-cycle after loading nonzero values -> Aout, Bout and Cout go to 0 immediately, before the next clk edge.
- Accumulate: en=1, WrEn=0, Cout=0; apply Ain=3, Bin=-4, then Ain=-2, Bin=-5 ->
  - after edge 1: Aout=3, Bout=-4, Cout=-12;
  - after edge 2: Cout=-2.
- Load: with Cout=-2, apply en=1, WrEn=1, Cin=16'h1234, Ain=7, Bin=7 -> Cout=16'h1234, Aout=7, Bout=7.
- Hold: en=0, WrEn=1, Ain=5, Bin=5, Cin=99 for 3 edges -> Aout, Bout and Cout unchanged.
- Extremes and wrap:
  - Ain=-128, Bin=-128 from Cout=0 -> Cout=16'h4000.
  - Then Ain=127, Bin=127 twice -> Cout=16384+16129=32513, then 32513+16129 wraps to -16894.
- Random: 256 cycles of random en, WrEn, Ain, Bin, Cin checked against a reference model of the rules above -> zero mismatches.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared widths and signed vector types for the systolic TPU processing elements.
package tpu_pkg;
  localparam int BITS_AB_DEF = 8;
  localparam int BITS_C_DEF  = 16;

  typedef logic signed [BITS_AB_DEF-1:0] ab_t;
  typedef logic signed [BITS_C_DEF-1:0]  c_t;
endpackage

// File: rtl/tpu_mac_mult.sv
// Signed multiplier with a BITS_C-wide result: full 2*BITS_AB product,
// then sign-extended or truncated to the accumulator width.
module tpu_mac_mult
  import tpu_pkg::*;
#(
  parameter int BITS_AB = BITS_AB_DEF,
  parameter int BITS_C  = BITS_C_DEF
) (
  input  logic [BITS_AB-1:0] i_a,
  input  logic [BITS_AB-1:0] i_b,
  output logic [BITS_C-1:0]  o_p
);
  localparam int PW = 2 * BITS_AB;

  logic signed [PW-1:0] w_prod;

  assign w_prod = $signed(i_a) * $signed(i_b);

  generate
    if (BITS_C > PW) begin : g_ext
      assign o_p = {{(BITS_C-PW){w_prod[PW-1]}}, w_prod};
    end else begin : g_trunc
      assign o_p = w_prod[BITS_C-1:0];
    end
  endgenerate
endmodule

// File: rtl/tpu_mac.sv
// Systolic-array MAC processing element: forwards A east and B south one
// cycle later, and accumulates A*B into C (or loads C directly).
module tpu_mac
  import tpu_pkg::*;
#(
  parameter int BITS_AB = BITS_AB_DEF,
  parameter int BITS_C  = BITS_C_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               WrEn,
  input  logic [BITS_AB-1:0] Ain,
  input  logic [BITS_AB-1:0] Bin,
  input  logic [BITS_C-1:0]  Cin,
  output logic [BITS_AB-1:0] Aout,
  output logic [BITS_AB-1:0] Bout,
  output logic [BITS_C-1:0]  Cout
);
  logic [BITS_AB-1:0] r_a;
  logic [BITS_AB-1:0] r_b;
  logic [BITS_C-1:0]  r_c;
  logic [BITS_C-1:0]  w_prod;

  // Product uses the live inputs, not the forwarded registers.
  tpu_mac_mult #(
    .BITS_AB(BITS_AB),
    .BITS_C (BITS_C)
  ) u_mult (
    .i_a(Ain),
    .i_b(Bin),
    .o_p(w_prod)
  );

  // rst_n is active-high despite its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_a <= '0;
      r_b <= '0;
      r_c <= '0;
    end else if (en) begin
      r_a <= Ain;
      r_b <= Bin;
      r_c <= WrEn ? Cin : r_c + w_prod;
    end
  end

  assign Aout = r_a;
  assign Bout = r_b;
  assign Cout = r_c;
endmodule

// File: tb/tb_tpu_mac.sv
// Scoreboard bench for tpu_mac: directed cases plus randomized traffic.
module tb_tpu_mac;
  import tpu_pkg::*;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] c;
  } exp_t;

  logic clk;
  logic rst_n;
  logic en;
  logic WrEn;
  ab_t  Ain;
  ab_t  Bin;
  c_t   Cin;
  logic [7:0]  Aout;
  logic [7:0]  Bout;
  logic [15:0] Cout;

  exp_t sb_q[$];
  logic [7:0]  m_a;
  logic [7:0]  m_b;
  logic [15:0] m_c;
  int n_checks;
  int n_errors;

  tpu_mac #(.BITS_AB(8), .BITS_C(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .WrEn (WrEn),
    .Ain  (Ain),
    .Bin  (Bin),
    .Cin  (Cin),
    .Aout (Aout),
    .Bout (Bout),
    .Cout (Cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Drive one cycle, update the reference model, push, then compare after the edge.
  task automatic step(input logic e, input logic w, input ab_t a, input ab_t b, input c_t c);
    exp_t ex;
    int   p;
    en   = e;
    WrEn = w;
    Ain  = a;
    Bin  = b;
    Cin  = c;
    if (e) begin
      p   = int'(a) * int'(b);
      m_c = w ? c : m_c + 16'(p);
      m_a = a;
      m_b = b;
    end
    ex.a = m_a;
    ex.b = m_b;
    ex.c = m_c;
    sb_q.push_back(ex);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_val("sb_empty", 16'd1, 16'd0);
    end else begin
      ex = sb_q.pop_front();
      check_val("sb_a", {8'h00, Aout}, {8'h00, ex.a});
      check_val("sb_b", {8'h00, Bout}, {8'h00, ex.b});
      check_val("sb_c", Cout, ex.c);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_a = '0;
    m_b = '0;
    m_c = '0;
    rst_n = 1'b1;
    en = 1'b0;
    WrEn = 1'b0;
    Ain = '0;
    Bin = '0;
    Cin = '0;
    #2;
    check_val("rst_a", {8'h00, Aout}, 16'h0000);
    check_val("rst_b", {8'h00, Bout}, 16'h0000);
    check_val("rst_c", Cout, 16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b0;

    // No enabled edge yet: outputs stay zero.
    step(1'b0, 1'b1, 8'sd9, 8'sd9, 16'sd9);
    check_val("post_rst_c", Cout, 16'h0000);

    step(1'b1, 1'b0, 8'sd3, -8'sd4, 16'sd0);
    check_val("acc1_a", {8'h00, Aout}, 16'h0003);
    check_val("acc1_b", {8'h00, Bout}, 16'h00FC);
    check_val("acc1_c", Cout, -16'sd12);
    step(1'b1, 1'b0, -8'sd2, -8'sd5, 16'sd0);
    check_val("acc2_c", Cout, -16'sd2);

    step(1'b1, 1'b1, 8'sd7, 8'sd7, 16'h1234);
    check_val("load_c", Cout, 16'h1234);
    check_val("load_a", {8'h00, Aout}, 16'h0007);

    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'sd5, 8'sd5, 16'sd99);
    check_val("hold_c", Cout, 16'h1234);
    check_val("hold_b", {8'h00, Bout}, 16'h0007);

    step(1'b1, 1'b1, 8'sd1, 8'sd1, 16'sd0);
    step(1'b1, 1'b0, -8'sd128, -8'sd128, 16'sd0);
    check_val("ext_neg", Cout, 16'h4000);
    step(1'b1, 1'b0, 8'sd127, 8'sd127, 16'sd0);
    check_val("ext_pos", Cout, 16'sd32513);
    step(1'b1, 1'b0, 8'sd127, 8'sd127, 16'sd0);
    check_val("ext_wrap", Cout, -16'sd16894);

    // Mid-cycle asynchronous reset with nonzero state.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("arst_a", {8'h00, Aout}, 16'h0000);
    check_val("arst_b", {8'h00, Bout}, 16'h0000);
    check_val("arst_c", Cout, 16'h0000);
    m_a = '0;
    m_b = '0;
    m_c = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;

    for (int i = 0; i < 256; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
           ab_t'($urandom), ab_t'($urandom), c_t'($urandom));
    end

    check_val("sb_drain", 16'(sb_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
